// File: rtl/td4_inst_encoder_if.sv
// Host/program-memory bundle for the TD4 instruction encoder.
// Optional feature macro: TD4_ENC_CHECKSUM_EN adds the checksum signal.
interface td4_inst_encoder_if #(
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_select;
    logic [3:0]        in_load;
    logic              in_jnc;
    logic [3:0]        in_imm;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              err;
`ifdef TD4_ENC_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    // Host side: issues session control and beats, observes the write port.
    modport master (
        output start, finish, in_valid, in_select, in_load, in_jnc, in_imm,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
`ifdef TD4_ENC_CHECKSUM_EN
        , input checksum
`endif
    );

    // Encoder side.
    modport slave (
        input  start, finish, in_valid, in_select, in_load, in_jnc, in_imm,
        output in_ready, mem_we, mem_addr, mem_wdata, count, busy, done, err
`ifdef TD4_ENC_CHECKSUM_EN
        , output checksum
`endif
    );
endinterface

// File: rtl/td4_inst_encoder.sv
// TD4 instruction encoder / program loader: turns {select, load, jnc, imm}
// beats into {opcode, imm} bytes written sequentially into program memory.
// Optional feature macro: TD4_ENC_CHECKSUM_EN (running mod-256 sum of writes).
module td4_inst_encoder #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    td4_inst_encoder_if.slave     bus
);
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [7:0]        r_mem_wdata;
    logic [CNT_W-1:0]  r_count;
    logic              r_err;
    logic              w_accept;
    logic              w_legal;
    logic [3:0]        w_opcode;
    logic              w_start_ok;
`ifdef TD4_ENC_CHECKSUM_EN
    logic [7:0]        r_checksum;
`endif

    assign w_accept   = bus.in_valid && (r_state == ST_LOAD);
    assign w_start_ok = bus.start && (r_state != ST_LOAD);

    // Reverse decode of {select, load} into the TD4 opcode.
    always_comb begin
        w_legal  = 1'b1;
        w_opcode = 4'h0;
        case ({bus.in_select, bus.in_load})
            6'b00_1110: w_opcode = 4'b0000;
            6'b01_1110: w_opcode = 4'b0001;
            6'b10_1110: w_opcode = 4'b0010;
            6'b11_1110: w_opcode = 4'b0011;
            6'b00_1101: w_opcode = 4'b0100;
            6'b01_1101: w_opcode = 4'b0101;
            6'b10_1101: w_opcode = 4'b0110;
            6'b11_1101: w_opcode = 4'b0111;
            6'b01_1011: w_opcode = 4'b1001;
            6'b11_1011: w_opcode = 4'b1011;
            6'b11_0111: w_opcode = bus.in_jnc ? 4'b1110 : 4'b1111;
            default:    w_legal  = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; the DEPTH-th legal write closes the session.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) w_state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (bus.finish || (w_accept && w_legal && (r_count == LAST_CNT)))
                    w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Write port, session counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_count     <= '0;
            r_err       <= 1'b0;
`ifdef TD4_ENC_CHECKSUM_EN
            r_checksum  <= 8'h00;
`endif
        end else begin
            r_mem_we <= 1'b0;
            if (w_start_ok) begin
                r_count    <= '0;
                r_err      <= 1'b0;
`ifdef TD4_ENC_CHECKSUM_EN
                r_checksum <= 8'h00;
`endif
            end else if (w_accept) begin
                if (w_legal) begin
                    r_mem_we    <= 1'b1;
                    r_mem_addr  <= r_count[ADDR_W-1:0];
                    r_mem_wdata <= {w_opcode, bus.in_imm};
                    r_count     <= r_count + CNT_W'(1);
`ifdef TD4_ENC_CHECKSUM_EN
                    r_checksum  <= r_checksum + {w_opcode, bus.in_imm};
`endif
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (r_state == ST_LOAD);
    assign bus.busy      = (r_state == ST_LOAD);
    assign bus.done      = (r_state == ST_DONE);
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.count     = r_count;
    assign bus.err       = r_err;
`ifdef TD4_ENC_CHECKSUM_EN
    assign bus.checksum  = r_checksum;
`endif
endmodule

// File: tb/tb_td4_inst_encoder.sv
// Directed bench for td4_inst_encoder.
module tb_td4_inst_encoder;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    td4_inst_encoder_if #(.ADDR_W(4)) bus ();

    td4_inst_encoder #(.DEPTH(16), .ADDR_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Opcode sweep table: {select, load}, jnc, imm, expected byte.
    logic [5:0] sw_fld [12] = '{6'b00_1110, 6'b01_1110, 6'b10_1110, 6'b11_1110,
                                6'b00_1101, 6'b01_1101, 6'b10_1101, 6'b11_1101,
                                6'b01_1011, 6'b11_1011, 6'b11_0111, 6'b11_0111};
    logic       sw_jnc [12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] sw_imm [12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5,
                                4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hA};
    logic [7:0] sw_exp [12] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55,
                                8'h66, 8'h77, 8'h98, 8'hB9, 8'hFA, 8'hEA};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start     = 1'b0;
        bus.finish    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_select = 2'b00;
        bus.in_load   = 4'hF;
        bus.in_jnc    = 1'b0;
        bus.in_imm    = 4'h0;
    endtask

    task automatic drive_beat(input logic [1:0] sel, input logic [3:0] ld,
                              input logic jnc, input logic [3:0] imm);
        bus.in_valid  = 1'b1;
        bus.in_select = sel;
        bus.in_load   = ld;
        bus.in_jnc    = jnc;
        bus.in_imm    = imm;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_finish();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", bus.mem_we); end
        n_checks++; if (bus.mem_addr !== 4'h0) begin n_fail++; $display("FAIL reset_addr got=%h exp=0", bus.mem_addr); end
        n_checks++; if (bus.mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_wdata got=%h exp=00", bus.mem_wdata); end
        n_checks++; if (bus.count !== 5'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        n_checks++; if (bus.err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", bus.err); end
        n_checks++; if ({bus.busy, bus.done, bus.in_ready} !== 3'b000) begin n_fail++; $display("FAIL reset_state got=%b exp=000", {bus.busy, bus.done, bus.in_ready}); end
        reset = 1'b0;
        tick();
        bus.finish = 1'b1;
        tick();
        bus.finish = 1'b0;
        n_checks++; if ({bus.busy, bus.done} !== 2'b00) begin n_fail++; $display("FAIL idle_finish got=%b exp=00", {bus.busy, bus.done}); end
    endtask

    task automatic test_basic_write();
        pulse_start();
        n_checks++; if ({bus.busy, bus.in_ready, bus.count} !== {2'b11, 5'd0}) begin n_fail++; $display("FAIL basic_start got=%b exp=1100000", {bus.busy, bus.in_ready, bus.count}); end
        drive_beat(2'b11, 4'b1110, 1'b0, 4'h5);
        tick();
        idle_inputs();
        n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'h0, 8'h35}) begin n_fail++; $display("FAIL basic_write got=%b/%h/%h exp=1/0/35", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        n_checks++; if ({bus.count, bus.err} !== {5'd1, 1'b0}) begin n_fail++; $display("FAIL basic_count got=%0d/%b exp=1/0", bus.count, bus.err); end
        tick();
        n_checks++; if ({bus.mem_we, bus.mem_wdata} !== {1'b0, 8'h35}) begin n_fail++; $display("FAIL basic_hold got=%b/%h exp=0/35", bus.mem_we, bus.mem_wdata); end
        pulse_finish();
        n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL basic_done got=%b exp=1", bus.done); end
    endtask

    task automatic test_opcode_sweep();
        pulse_start();
        for (int i = 0; i < 12; i++) begin
            drive_beat(sw_fld[i][5:4], sw_fld[i][3:0], sw_jnc[i], sw_imm[i]);
            tick();
            n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'(i), sw_exp[i]}) begin n_fail++; $display("FAIL sweep_%0d got=%b/%h/%h exp=1/%h/%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, 4'(i), sw_exp[i]); end
        end
        idle_inputs();
        tick();
        n_checks++; if ({bus.mem_we, bus.count, bus.busy} !== {1'b0, 5'd12, 1'b1}) begin n_fail++; $display("FAIL sweep_end got=%b/%0d/%b exp=0/12/1", bus.mem_we, bus.count, bus.busy); end
        pulse_finish();
    endtask

    task automatic test_illegal();
        pulse_start();
        n_checks++; if ({bus.err, bus.count} !== {1'b0, 5'd0}) begin n_fail++; $display("FAIL ill_restart got=%b/%0d exp=0/0", bus.err, bus.count); end
        drive_beat(2'b00, 4'b1011, 1'b0, 4'h7);
        tick();
        n_checks++; if ({bus.mem_we, bus.count, bus.err} !== {1'b0, 5'd0, 1'b1}) begin n_fail++; $display("FAIL ill_beat got=%b/%0d/%b exp=0/0/1", bus.mem_we, bus.count, bus.err); end
        drive_beat(2'b01, 4'b1011, 1'b0, 4'h7);
        tick();
        n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count, bus.err} !== {1'b1, 4'h0, 8'h97, 5'd1, 1'b1}) begin n_fail++; $display("FAIL ill_next got=%b/%h/%h/%0d/%b exp=1/0/97/1/1", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count, bus.err); end
        drive_beat(2'b10, 4'b0111, 1'b1, 4'h2);
        tick();
        n_checks++; if ({bus.mem_we, bus.count} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL ill_pc_sel got=%b/%0d exp=0/1", bus.mem_we, bus.count); end
        drive_beat(2'b00, 4'b1111, 1'b0, 4'h2);
        tick();
        n_checks++; if ({bus.mem_we, bus.count} !== {1'b0, 5'd1}) begin n_fail++; $display("FAIL ill_noload got=%b/%0d exp=0/1", bus.mem_we, bus.count); end
        idle_inputs();
        pulse_finish();
        n_checks++; if ({bus.done, bus.err} !== 2'b11) begin n_fail++; $display("FAIL ill_sticky got=%b exp=11", {bus.done, bus.err}); end
        pulse_start();
        n_checks++; if ({bus.busy, bus.err} !== 2'b10) begin n_fail++; $display("FAIL ill_clear got=%b exp=10", {bus.busy, bus.err}); end
        pulse_finish();
    endtask

    task automatic test_capacity();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            drive_beat(2'b10, 4'b1101, 1'b0, 4'(i));
            tick();
            n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 4'(i), 4'h6, 4'(i)}) begin n_fail++; $display("FAIL cap_%0d got=%b/%h/%h exp=1/%h/6%h", i, bus.mem_we, bus.mem_addr, bus.mem_wdata, 4'(i), 4'(i)); end
        end
        n_checks++; if ({bus.count, bus.done, bus.busy, bus.in_ready} !== {5'd16, 3'b100}) begin n_fail++; $display("FAIL cap_full got=%0d/%b exp=16/100", bus.count, {bus.done, bus.busy, bus.in_ready}); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({bus.mem_we, bus.count} !== {1'b0, 5'd16}) begin n_fail++; $display("FAIL cap_extra_%0d got=%b/%0d exp=0/16", i, bus.mem_we, bus.count); end
        end
        idle_inputs();
        pulse_start();
        drive_beat(2'b00, 4'b1110, 1'b0, 4'hF);
        tick();
        idle_inputs();
        n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count} !== {1'b1, 4'h0, 8'h0F, 5'd1}) begin n_fail++; $display("FAIL cap_restart got=%b/%h/%h/%0d exp=1/0/0f/1", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count); end
        pulse_finish();
    endtask

    task automatic test_early_finish();
        pulse_start();
        drive_beat(2'b00, 4'b1101, 1'b0, 4'h1);
        tick();
        idle_inputs();
        pulse_start();
        n_checks++; if ({bus.busy, bus.count, bus.mem_we} !== {1'b1, 5'd1, 1'b0}) begin n_fail++; $display("FAIL start_in_load got=%b/%0d/%b exp=1/1/0", bus.busy, bus.count, bus.mem_we); end
        drive_beat(2'b01, 4'b1101, 1'b0, 4'h3);
        bus.finish = 1'b1;
        tick();
        idle_inputs();
        n_checks++; if ({bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count, bus.done} !== {1'b1, 4'h1, 8'h53, 5'd2, 1'b1}) begin n_fail++; $display("FAIL finish_beat got=%b/%h/%h/%0d/%b exp=1/1/53/2/1", bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.count, bus.done); end
        tick();
        n_checks++; if ({bus.mem_we, bus.done, bus.count} !== {2'b01, 5'd2}) begin n_fail++; $display("FAIL finish_after got=%b/%b/%0d exp=0/1/2", bus.mem_we, bus.done, bus.count); end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        drive_beat(2'b11, 4'b1110, 1'b0, 4'h5);
        tick();
        n_checks++; if (bus.mem_we !== 1'b1) begin n_fail++; $display("FAIL rst_mid_pre got=%b exp=1", bus.mem_we); end
        drive_beat(2'b11, 4'b0111, 1'b0, 4'hA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        idle_inputs();
        n_checks++; if ({bus.mem_we, bus.busy, bus.done, bus.count, bus.err} !== {3'b000, 5'd0, 1'b0}) begin n_fail++; $display("FAIL rst_mid got=%b/%b/%b/%0d/%b exp=0/0/0/0/0", bus.mem_we, bus.busy, bus.done, bus.count, bus.err); end
        n_checks++; if ({bus.mem_addr, bus.mem_wdata} !== 12'h000) begin n_fail++; $display("FAIL rst_mid_bus got=%h/%h exp=0/00", bus.mem_addr, bus.mem_wdata); end
    endtask

`ifdef TD4_ENC_CHECKSUM_EN
    task automatic test_checksum();
        pulse_start();
        n_checks++; if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL csum_start got=%h exp=00", bus.checksum); end
        drive_beat(2'b11, 4'b1110, 1'b0, 4'h5);
        tick();
        n_checks++; if (bus.checksum !== 8'h35) begin n_fail++; $display("FAIL csum_1 got=%h exp=35", bus.checksum); end
        drive_beat(2'b11, 4'b0111, 1'b0, 4'hA);
        tick();
        n_checks++; if (bus.checksum !== 8'h2F) begin n_fail++; $display("FAIL csum_2 got=%h exp=2f", bus.checksum); end
        drive_beat(2'b00, 4'b1011, 1'b0, 4'h7);
        tick();
        idle_inputs();
        n_checks++; if (bus.checksum !== 8'h2F) begin n_fail++; $display("FAIL csum_ill got=%h exp=2f", bus.checksum); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (bus.checksum !== 8'h00) begin n_fail++; $display("FAIL csum_reset got=%h exp=00", bus.checksum); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_write();
        test_opcode_sweep();
        test_illegal();
        test_capacity();
        test_early_finish();
        test_reset_mid();
`ifdef TD4_ENC_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
